// File: rtl/kernel_pkg.sv
// Shared constants, state encoding and sizing helper for the run-time loadable
// 3x3 kernel weight store.
package kernel_pkg;

  localparam int TAPS            = 9;
  localparam int DATA_W_DEF      = 8;
  localparam int NUM_KERNELS_DEF = 8;
  localparam int DEPTH           = NUM_KERNELS_DEF * TAPS;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_e;

  function automatic int kernel_depth(input int num_kernels);
    return num_kernels * TAPS;
  endfunction

endpackage

// File: rtl/kernel_regfile.sv
// Byte-wide weight bank with one write port and a combinational nine-tap read
// port addressed by kernel index; out-of-range kernels read as zero.
module kernel_regfile
  import kernel_pkg::*;
#(
  parameter int NUM_KERNELS = NUM_KERNELS_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  localparam int MEM_DEPTH  = kernel_depth(NUM_KERNELS),
  localparam int AW         = $clog2(MEM_DEPTH)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         we_i,
  input  logic [AW-1:0]                waddr_i,
  input  logic [DATA_W-1:0]            wdata_i,
  input  logic [3:0]                   rd_addr_i,
  output logic [TAPS-1:0][DATA_W-1:0]  k_o
);

  localparam logic [4:0] NK = 5'(NUM_KERNELS);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic              in_range;

  assign in_range = {1'b0, rd_addr_i} < NK;

  // NOTE: the bank is cleared on reset because the conv engine may read it
  // before any load; non-blocking assignments keep every flop updating from
  // pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // NOTE: k_o gets a default before the guarded loop so no path infers a latch.
  always_comb begin
    k_o = '0;
    if (in_range) begin
      for (int i = 0; i < TAPS; i++) begin
        k_o[i] = mem_q[AW'(int'(rd_addr_i) * TAPS + i)];
      end
    end
  end

endmodule

// File: rtl/kernel_loader.sv
// Streams 3x3 kernel weights into the register bank, tracks completed kernels
// and flags streams that end early.
module kernel_loader
  import kernel_pkg::*;
#(
  parameter int NUM_KERNELS = NUM_KERNELS_DEF,
  parameter int DATA_W      = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              s_valid_i,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_last_i,
  output logic              s_ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  input  logic [3:0]        rd_addr_i,
  output logic [DATA_W-1:0] k0_o,
  output logic [DATA_W-1:0] k1_o,
  output logic [DATA_W-1:0] k2_o,
  output logic [DATA_W-1:0] k3_o,
  output logic [DATA_W-1:0] k4_o,
  output logic [DATA_W-1:0] k5_o,
  output logic [DATA_W-1:0] k6_o,
  output logic [DATA_W-1:0] k7_o,
  output logic [DATA_W-1:0] k8_o,
  output logic              rd_valid_o
);

  localparam int         MEM_DEPTH = kernel_depth(NUM_KERNELS);
  localparam int         AW        = $clog2(MEM_DEPTH);
  localparam logic [4:0] NK        = 5'(NUM_KERNELS);

  state_e                  state_q, state_d;
  logic [AW-1:0]           wptr_q, wptr_d;
  logic [3:0]              tap_q, tap_d;
  logic [4:0]              kidx_q, kidx_d;
  logic [NUM_KERNELS-1:0]  loaded_q, loaded_d;
  logic                    err_q, err_d;

  logic                    accept, write_en, final_beat;
  logic [NUM_KERNELS-1:0]  loaded_sh;
  logic [TAPS-1:0][DATA_W-1:0] k;

  assign accept     = s_valid_i && (state_q == LOAD);
  // A start in the same cycle as a beat wins; the beat is dropped.
  assign write_en   = accept && !start_i;
  assign final_beat = (wptr_q == AW'(MEM_DEPTH - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = LOAD;
      LOAD:    if (start_i) state_d = LOAD;
               else if (write_en && (final_beat || s_last_i)) state_d = DONE;
      DONE:    if (start_i) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_ready_o = 1'b0;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    unique case (state_q)
      LOAD:    begin s_ready_o = 1'b1; busy_o = 1'b1; end
      DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    wptr_d   = wptr_q;
    tap_d    = tap_q;
    kidx_d   = kidx_q;
    loaded_d = loaded_q;
    err_d    = err_q;
    if (start_i) begin
      wptr_d   = '0;
      tap_d    = '0;
      kidx_d   = '0;
      loaded_d = '0;
      err_d    = 1'b0;
    end else if (write_en) begin
      wptr_d = wptr_q + 1'b1;
      if (tap_q == 4'(TAPS - 1)) begin
        tap_d    = '0;
        loaded_d = loaded_q | (NUM_KERNELS'(1) << kidx_q);
        kidx_d   = kidx_q + 1'b1;
      end else begin
        tap_d = tap_q + 1'b1;
      end
      if (s_last_i && !final_beat) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q   <= '0;
      tap_q    <= '0;
      kidx_q   <= '0;
      loaded_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      tap_q    <= tap_d;
      kidx_q   <= kidx_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
    end
  end

  kernel_regfile #(
    .NUM_KERNELS (NUM_KERNELS),
    .DATA_W      (DATA_W)
  ) u_regfile (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .we_i      (write_en),
    .waddr_i   (wptr_q),
    .wdata_i   (s_data_i),
    .rd_addr_i (rd_addr_i),
    .k_o       (k)
  );

  assign err_o      = err_q;
  assign loaded_sh  = loaded_q >> rd_addr_i;
  assign rd_valid_o = ({1'b0, rd_addr_i} < NK) && loaded_sh[0];

  assign k0_o = k[0];
  assign k1_o = k[1];
  assign k2_o = k[2];
  assign k3_o = k[3];
  assign k4_o = k[4];
  assign k5_o = k[5];
  assign k6_o = k[6];
  assign k7_o = k[7];
  assign k8_o = k[8];

endmodule
